ifu_fetch: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the control decoder.
- Holds the PC and fetches one 32-bit word from instruction memory over a req/ack handshake.
- Presents the word, its op/func fields and its PC to decode and execute with valid/ready.
- On retirement, computes the next PC from the Branch/Jump/zero feedback of the datapath.

---
 rtl/ifu_pkg.sv | 21 ++
 rtl/ifu_next_pc.sv | 31 +++
 rtl/ifu_fetch.sv | 125 ++++++++++++
 tb/tb_ifu_fetch.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional performance counters are enabled with the IFU_PERF_CNT_EN macro.
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int FUNC_W = 6;
  localparam int IMM_W  = 16;
  localparam int JTGT_W = 26;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

endpackage

// File: rtl/ifu_next_pc.sv
// Combinational next-PC computation for a retiring instruction.
// Jump beats a taken branch; all arithmetic wraps modulo 2^32.
module ifu_next_pc
  import ifu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        zero,
  output logic [31:0] next_pc
);

  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [31:0] jmp_tgt;

  assign pc4     = pc + 32'd4;
  assign br_off  = {{(32-IMM_W-2){instr[IMM_W-1]}}, instr[IMM_W-1:0], 2'b00};
  assign jmp_tgt = {pc4[31:28], instr[JTGT_W-1:0], 2'b00};

  always_comb begin
    next_pc = pc4;
    if (Jump) begin
      next_pc = jmp_tgt;
    end else if (Branch && zero) begin
      next_pc = pc4 + br_off;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: req/ack fetch from imem, valid/ready issue to decode.
// Define IFU_PERF_CNT_EN to add the retire_cnt / stall_cnt counter outputs.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000  // must be word-aligned
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic [31:0] pc,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        zero
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] retire_cnt,
  output logic [31:0] stall_cnt
`endif
);

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic        req_reg, req_next;
  logic        valid_reg, valid_next;
  logic [31:0] npc;

  ifu_next_pc u_next_pc (
    .pc      (pc_reg),
    .instr   (instr_reg),
    .Branch  (Branch),
    .Jump    (Jump),
    .zero    (zero),
    .next_pc (npc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
      instr_reg <= 32'd0;
      req_reg   <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      req_reg   <= req_next;
      valid_reg <= valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    req_next   = req_reg;
    valid_next = valid_reg;
    case (state_reg)
      IDLE: begin
        state_next = FETCH;
        req_next   = 1'b1;
      end
      FETCH: begin
        if (imem_ack) begin
          instr_next = imem_rdata;
          req_next   = 1'b0;
          valid_next = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        // Feedback is only consulted here, in the retire cycle.
        if (instr_ready) begin
          pc_next    = npc;
          valid_next = 1'b0;
          req_next   = 1'b1;
          state_next = FETCH;
        end
      end
      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
        valid_next = 1'b0;
      end
    endcase
  end

  assign imem_req    = req_reg;
  assign imem_addr   = pc_reg;
  assign instr_valid = valid_reg;
  assign instr       = instr_reg;
  assign pc          = pc_reg;
  assign op          = instr_reg[OP_MSB:OP_LSB];
  assign func        = instr_reg[FUNC_W-1:0];

`ifdef IFU_PERF_CNT_EN
  logic retire;
  logic stall;

  assign retire = (state_reg == ISSUE) && instr_ready;
  assign stall  = ((state_reg == FETCH) && !imem_ack) ||
                  ((state_reg == ISSUE) && !instr_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= 32'd0;
      stall_cnt  <= 32'd0;
    end else begin
      if (retire) retire_cnt <= retire_cnt + 32'd1;
      if (stall)  stall_cnt  <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch; a second instance with a high
// RESET_PC covers the jump-region case.
module tb_ifu_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst2_n;
  logic        imem_ack, instr_ready, Branch, Jump, zero, ovr;
  logic [31:0] rom [0:15];
  logic [31:0] imem_rdata, rdata2;

  logic        imem_req, instr_valid, req2, valid2;
  logic [31:0] imem_addr, instr, pc, addr2, instr2, pc2;
  logic [5:0]  op, func, op2, func2;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] retire_cnt, stall_cnt, rc2, sc2, rc0, sc0;
`endif

  assign imem_rdata = ovr ? 32'hDEAD_BEEF : rom[imem_addr[5:2]];
  assign rdata2     = 32'h0800_0100;

  ifu_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .op(op), .func(func), .pc(pc),
    .Branch(Branch), .Jump(Jump), .zero(zero)
`ifdef IFU_PERF_CNT_EN
    , .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
`endif
  );

  ifu_fetch #(.RESET_PC(32'h4000_0010)) u_dut_hi (
    .clk(clk), .rst_n(rst2_n), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(imem_ack), .imem_rdata(rdata2), .instr_valid(valid2),
    .instr_ready(instr_ready), .instr(instr2), .op(op2), .func(func2), .pc(pc2),
    .Branch(Branch), .Jump(Jump), .zero(zero)
`ifdef IFU_PERF_CNT_EN
    , .retire_cnt(rc2), .stall_cnt(sc2)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) begin
      $display("[TB] ok %s = %h", tag, obs);
    end else begin
      fails++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    imem_ack = 1'b0; instr_ready = 1'b0;
    Branch = 1'b0; Jump = 1'b0; zero = 1'b0; ovr = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 32'h0000_0000;
    rom[0]  = 32'h0000_0020;  // R-type, func 0x20
    rom[1]  = 32'h8C22_0004;  // op 0x23, func 0x04
    rom[2]  = 32'h0800_0008;  // j 0x20
    rom[7]  = 32'h0800_0008;  // @0x1C: j 0x20
    rom[8]  = 32'h1000_FFFE;  // @0x20: beq -2
    rom[9]  = 32'h0123_4567;  // @0x24: plain word
    rom[10] = 32'h1000_FFF4;  // @0x28: beq -12 -> 0xFFFF_FFFC
    rom[15] = 32'h0000_0000;  // @0xFFFF_FFFC

    tick(); tick();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);

    // Release just after an edge; that edge counts as the first.
    rst_n = 1'b1; imem_ack = 1'b1; instr_ready = 1'b1;
    #1 check("req_at_release", {31'd0, imem_req}, 32'd0);
    tick();
    check("req_rise", {31'd0, imem_req}, 32'd1);
    check("addr0", imem_addr, 32'h0);
    tick();
    check("valid0", {31'd0, instr_valid}, 32'd1);
    check("instr0", instr, 32'h0000_0020);
    check("op0", {26'd0, op}, 32'h00);
    check("func0", {26'd0, func}, 32'h20);
    check("req_drop", {31'd0, imem_req}, 32'd0);
    tick();
    check("addr4", imem_addr, 32'h4);
    tick();
    check("op1", {26'd0, op}, 32'h23);
    check("func1", {26'd0, func}, 32'h04);
    tick();
    check("addr8", imem_addr, 32'h8);
    tick();
    check("op2", {26'd0, op}, 32'h02);
    check("func2", {26'd0, func}, 32'h08);
    Jump = 1'b1;
    tick();
    Jump = 1'b0;
    check("jump_0x20", imem_addr, 32'h20);
    Branch = 1'b1; zero = 1'b1;
    tick();
    check("instr_beq", instr, 32'h1000_FFFE);
    tick();
    check("beq_taken", imem_addr, 32'h1C);
    Branch = 1'b0; zero = 1'b0;
    tick();
    Jump = 1'b1;
    tick();
    Jump = 1'b0;
    check("jump_back", imem_addr, 32'h20);
    Branch = 1'b1; zero = 1'b0;
    tick();
    tick();
    check("beq_not_taken", imem_addr, 32'h24);
    Branch = 1'b0;

    // Backpressure: 3 cycles without ack, then 4 cycles without ready.
    imem_ack = 1'b0; instr_ready = 1'b0;
`ifdef IFU_PERF_CNT_EN
    rc0 = retire_cnt; sc0 = stall_cnt;
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_fetch_addr", imem_addr, 32'h24);
      check("bp_fetch_req", {31'd0, imem_req}, 32'd1);
      check("bp_fetch_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_ack = 1'b1;
    tick();
    check("bp_instr", instr, 32'h0123_4567);
    ovr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_issue_instr", instr, 32'h0123_4567);
      check("bp_issue_pc", pc, 32'h24);
      check("bp_issue_valid", {31'd0, instr_valid}, 32'd1);
    end
    instr_ready = 1'b1; imem_ack = 1'b0; ovr = 1'b0;
    tick();
    check("bp_retire_addr", imem_addr, 32'h28);
    check("bp_retire_req", {31'd0, imem_req}, 32'd1);
`ifdef IFU_PERF_CNT_EN
    check("perf_retire", retire_cnt - rc0, 32'd1);
    check("perf_stall", stall_cnt - sc0, 32'd7);
`endif

    // Negative branch to the top word, then wrap to zero.
    imem_ack = 1'b1; Branch = 1'b1; zero = 1'b1;
    tick();
    tick();
    check("neg_branch", imem_addr, 32'hFFFF_FFFC);
    Branch = 1'b0; zero = 1'b0;
    tick();
    tick();
    check("pc_wrap", imem_addr, 32'h0);
    tick();
    tick();
    check("addr4_again", imem_addr, 32'h4);

    // Reset mid-FETCH with an ack in the same cycle.
    imem_ack = 1'b0;
    tick();
    imem_ack = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req", {31'd0, imem_req}, 32'd0);
    check("midrst_valid", {31'd0, instr_valid}, 32'd0);
    check("midrst_pc", pc, 32'h0);
    check("midrst_instr", instr, 32'h0);
    tick();
    check("midrst_instr_hold", instr, 32'h0);

    // High-region instance: Jump beats Branch.
    rst2_n = 1'b1; imem_ack = 1'b1; instr_ready = 1'b1;
    Jump = 1'b0; Branch = 1'b0; zero = 1'b0;
    tick();
    check("hi_req", {31'd0, req2}, 32'd1);
    check("hi_addr", addr2, 32'h4000_0010);
    tick();
    check("hi_instr", instr2, 32'h0800_0100);
    check("hi_op", {26'd0, op2}, 32'h02);
    Jump = 1'b1; Branch = 1'b1; zero = 1'b1;
    tick();
    check("jump_wins", addr2, 32'h4000_0400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
